// File: rtl/rr_req_ack_arbiter.sv
// Round-robin arbiter sharing one req/ack resource among N requesters.
// Optional assertions are enabled by defining RR_ARB_ASSERT_EN.
//
// Ports:
//   clk       : clock, all state updates on the rising edge
//   rst       : asynchronous active-high reset
//   req       : level request, one bit per requester
//   req_data  : requester data, slice i = req_data[i*DW +: DW]
//   ack       : one-cycle completion pulse to the granted requester
//   grant     : one-hot0 owner, held for the whole transaction
//   res_valid : request to the shared resource (== |grant)
//   res_data  : data to the resource, latched at grant time
//   res_ack   : resource acknowledge
//   error     : one-cycle pulse when a transaction times out
//   err_cnt   : saturating count of timeouts
module rr_req_ack_arbiter #(
    parameter int N       = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] req_data,
    output logic [N-1:0]    ack,
    output logic [N-1:0]    grant,
    output logic            res_valid,
    output logic [DW-1:0]   res_data,
    input  logic            res_ack,
    output logic            error,
    output logic [7:0]      err_cnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   idx_q, idx_d;
    logic [3:0]      wait_q, wait_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [DW-1:0]   data_q, data_d;
    logic [N-1:0]    ack_q, ack_d;
    logic            error_q, error_d;
    logic [7:0]      err_cnt_q, err_cnt_d;

    logic            pick_vld;
    logic [PW-1:0]   pick_idx;
    logic [DW-1:0]   pick_data;
    logic            timeout_hit;
    logic [PW-1:0]   ptr_nxt;

    // Round-robin pick: first set request at or after ptr, wrapping.
    // Scanning from the farthest offset down lets the nearest hit win.
    always_comb begin
        logic [PW:0] pos;
        pick_vld = 1'b0;
        pick_idx = '0;
        pos      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = {1'b0, ptr_q} + (PW+1)'(k);
            if (pos >= (PW+1)'(N)) begin
                pos = pos - (PW+1)'(N);
            end
            if (req[pos[PW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = pos[PW-1:0];
            end
        end
    end

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_idx == PW'(i)) begin
                pick_data = req_data[i*DW +: DW];
            end
        end
    end

    // wait_q counts completed res_valid cycles without ack; the
    // TIMEOUT-th such cycle ends the transaction.
    assign timeout_hit = (wait_q == 4'(TIMEOUT - 1));
    assign ptr_nxt     = (idx_q == PW'(N - 1)) ? '0 : idx_q + 1'b1;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (res_ack || timeout_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        wait_d    = wait_q;
        grant_d   = grant_q;
        data_d    = data_q;
        ack_d     = '0;
        error_d   = 1'b0;
        err_cnt_d = err_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    idx_d   = pick_idx;
                    grant_d = N'(1) << pick_idx;
                    data_d  = pick_data;
                    wait_d  = '0;
                end
            end
            BUSY: begin
                // An ack on the final cycle takes priority over timeout.
                if (res_ack) begin
                    ack_d   = grant_q;
                    grant_d = '0;
                    ptr_d   = ptr_nxt;
                end else if (timeout_hit) begin
                    error_d = 1'b1;
                    grant_d = '0;
                    ptr_d   = ptr_nxt;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            default: begin
                grant_d = '0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            idx_q     <= '0;
            wait_q    <= '0;
            grant_q   <= '0;
            data_q    <= '0;
            ack_q     <= '0;
            error_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            wait_q    <= wait_d;
            grant_q   <= grant_d;
            data_q    <= data_d;
            ack_q     <= ack_d;
            error_q   <= error_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign grant     = grant_q;
    assign res_valid = |grant_q;
    assign res_data  = data_q;
    assign ack       = ack_q;
    assign error     = error_q;
    assign err_cnt   = err_cnt_q;

`ifdef RR_ARB_ASSERT_EN
    a_grant_onehot0: assert property (
        @(posedge clk) disable iff (rst)
        $onehot0(grant)
    );

    // Anchored on the first valid cycle: transactions are separated
    // by at least one idle cycle, so each one starts with a rise.
    a_ack_or_timeout: assert property (
        @(posedge clk) disable iff (rst)
        $rose(res_valid) |->
            (##[0:TIMEOUT-1] res_ack) or (##TIMEOUT error)
    );

    a_no_ack_with_error: assert property (
        @(posedge clk) disable iff (rst)
        !(error && |ack)
    );

    a_data_stable: assert property (
        @(posedge clk) disable iff (rst)
        res_valid && !res_ack |=> $stable(res_data)
    );

    for (genvar gi = 0; gi < N; gi++) begin : g_ack_chk
        a_ack_granted: assert property (
            @(posedge clk) disable iff (rst)
            ack[gi] |-> $past(grant[gi])
        );
    end

    c_req0_ack0: cover property (
        @(posedge clk) disable iff (rst)
        req[0] ##1 grant[0] ##[1:TIMEOUT] ack[0]
    );
`else
`endif

endmodule
